// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
// The master side requests additions; the slave side (the adder) reports
// progress and the registered result.
interface serial_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] op_A;
    logic [WIDTH-1:0] op_B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;

    modport master (
        output start,
        output op_A,
        output op_B,
        input  busy,
        input  done,
        input  sum,
        input  carry_out
    );

    modport slave (
        input  start,
        input  op_A,
        input  op_B,
        output busy,
        output done,
        output sum,
        output carry_out
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: two WIDTH-bit operands are summed one bit per clock,
// LSB first, using a full adder built from two half-adder cells and an OR.
// A carry flop links consecutive bits. Start/done handshake with busy flag.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    serial_adder_if.slave bus
);

    // Counter wide enough to index WIDTH bits (at least one bit for WIDTH=1).
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] res_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    // Full-adder datapath signals for the current bit.
    logic             ha0_sum;
    logic             ha0_carry;
    logic             ha1_carry;
    logic             bit_d;
    logic             carry_d;
    logic [WIDTH-1:0] res_d;

    // First half adder: operand bits.
    half_adder_structural u_ha0 (
        .a_i     (a_sr_q[0]),
        .b_i     (b_sr_q[0]),
        .sum_o   (ha0_sum),
        .carry_o (ha0_carry)
    );

    // Second half adder: partial sum plus the stored carry.
    half_adder_structural u_ha1 (
        .a_i     (ha0_sum),
        .b_i     (carry_q),
        .sum_o   (bit_d),
        .carry_o (ha1_carry)
    );

    // Carry out of the full adder is the OR of both half-adder carries.
    always_comb begin
        carry_d = ha0_carry | ha1_carry;
    end

    // Result register shifts right with the new bit entering at the MSB.
    generate
        if (WIDTH == 1) begin : g_res_w1
            always_comb begin
                res_d = bit_d;
            end
        end else begin : g_res_wn
            always_comb begin
                res_d = {bit_d, res_q[WIDTH-1:1]};
            end
        end
    endgenerate

    // Control FSM and datapath registers; outputs are registered here too.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_sr_q  <= bus.op_A;
                        b_sr_q  <= bus.op_B;
                        carry_q <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    a_sr_q  <= a_sr_q >> 1;
                    b_sr_q  <= b_sr_q >> 1;
                    res_q   <= res_d;
                    carry_q <= carry_d;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        sum_q   <= res_d;
                        cout_q  <= carry_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Single-cycle result strobe; start is ignored here.
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Drive interface outputs from the registered state.
    always_comb begin
        bus.busy      = busy_q;
        bus.done      = done_q;
        bus.sum       = sum_q;
        bus.carry_out = cout_q;
    end

endmodule

// Half-adder cell: sum is XOR, carry is AND of the two inputs.
module half_adder_structural (
    input  logic a_i,
    input  logic b_i,
    output logic sum_o,
    output logic carry_o
);

    // Pure combinational cell.
    always_comb begin
        sum_o   = a_i ^ b_i;
        carry_o = a_i & b_i;
    end

endmodule
